// File: rtl/acq_trigger_scheduler.sv
// acq_trigger_scheduler
//   Run-level controller for the slave DAQ block. A run is started from USB,
//   holds ModuleStart high, issues AcqStart pulses (internally timed or from
//   a synchronized external trigger) one per completed readout, and stops
//   after AcqNumber acquisitions or on a USB stop request. Run completion is
//   reported only after the slave's AllDone handshake.
//
// Ports
//   Clk, reset_n   system clock, asynchronous active-low reset
//   RunStart       1-cycle pulse, starts a run (ignored while running)
//   RunStop        1-cycle pulse, requests the run to stop
//   TrigMode       1 = internal periodic trigger, 0 = external trigger
//   ExtTrig        asynchronous external trigger, rising-edge active
//   TrigPeriod     internal trigger wait in cycles (0 treated as 1)
//   TrigWidth      AcqStart pulse width in cycles (0 treated as 1)
//   AcqNumber      acquisitions per run, 0 = unlimited
//   OnceEnd        slave readout-complete level
//   AllDone        slave data-transmit-complete handshake
//   ModuleStart    run enable to slave DAQ
//   AcqStart       trigger pulse to slave DAQ
//   Running        high whenever not idle
//   RunDone        1-cycle pulse at end of run
//   AcqCount       completed acquisitions in the current run
//   TrigDropped    external edges seen while busy, saturating

module acq_trigger_scheduler #(
  parameter int unsigned ARM_DELAY   = 64,
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        RunStart,
  input  logic        RunStop,
  input  logic        TrigMode,
  input  logic        ExtTrig,
  input  logic [15:0] TrigPeriod,
  input  logic [7:0]  TrigWidth,
  input  logic [15:0] AcqNumber,
  input  logic        OnceEnd,
  input  logic        AllDone,
  output logic        ModuleStart,
  output logic        AcqStart,
  output logic        Running,
  output logic        RunDone,
  output logic [15:0] AcqCount,
  output logic [15:0] TrigDropped
);

  typedef enum logic [2:0] {
    StIdle, StArm, StWaitTrig, StTrigPulse, StWaitOnceEnd, StWaitOnceClr, StStopping, StDone
  } stateT;

  stateT stateQ, stateD;

  logic [SYNC_STAGES-1:0] extSyncQ;
  logic                   extPrevQ;
  logic                   extEdge;
  logic [15:0]            cntQ, cntD;
  logic                   stopReqQ;
  logic                   stopEff;
  logic                   runDoneQ;
  logic [15:0]            acqCountQ;
  logic [15:0]            acqCountInc;
  logic [15:0]            trigDroppedQ;
  logic [15:0]            periodEff;
  logic [7:0]             widthEff;
  logic                   armDone;
  logic                   runLaunch;

  // External trigger synchronizer and rising-edge detect
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      extSyncQ <= '0;
      extPrevQ <= 1'b0;
    end else begin
      extSyncQ <= {extSyncQ[SYNC_STAGES-2:0], ExtTrig};
      extPrevQ <= extSyncQ[SYNC_STAGES-1];
    end
  end

  assign extEdge     = extSyncQ[SYNC_STAGES-1] & ~extPrevQ;
  assign periodEff   = (TrigPeriod == 16'd0) ? 16'd1 : TrigPeriod;
  assign widthEff    = (TrigWidth == 8'd0) ? 8'd1 : TrigWidth;
  assign acqCountInc = acqCountQ + 16'd1;
  assign armDone     = (32'(cntQ) + 32'd1) >= ARM_DELAY;
  assign runLaunch   = (stateQ == StIdle) && RunStart && !RunStop;
  // A stop pulse arriving this cycle is honoured as if already latched
  assign stopEff     = stopReqQ | RunStop;

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:        if (runLaunch) stateD = StArm;
      StArm:         if (armDone) stateD = stopEff ? StStopping : StWaitTrig;
      StWaitTrig: begin
        if (stopEff) begin
          stateD = StStopping;
        end else if (TrigMode ? (cntQ == periodEff) : extEdge) begin
          stateD = StTrigPulse;
        end
      end
      StTrigPulse:   if (cntQ == {8'h00, widthEff - 8'd1}) stateD = StWaitOnceEnd;
      StWaitOnceEnd: if (OnceEnd) stateD = StWaitOnceClr;
      StWaitOnceClr: begin
        if (!OnceEnd) begin
          if (stopEff || ((AcqNumber != 16'd0) && (acqCountInc == AcqNumber))) begin
            stateD = StStopping;
          end else begin
            stateD = StWaitTrig;
          end
        end
      end
      StStopping:    if (AllDone) stateD = StDone;
      StDone:        if (!AllDone) stateD = StIdle;
      default:       stateD = StIdle;
    endcase
  end

  // Shared per-state cycle counter, restarts from 0 on every state change
  always_comb begin
    cntD = (stateD != stateQ) ? 16'd0 : cntQ + 16'd1;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cntQ         <= '0;
      stopReqQ     <= 1'b0;
      runDoneQ     <= 1'b0;
      acqCountQ    <= '0;
      trigDroppedQ <= '0;
    end else begin
      cntQ     <= cntD;
      runDoneQ <= (stateD == StDone) && (stateQ != StDone);
      if (stateD == StIdle) begin
        stopReqQ <= 1'b0;
      end else if (RunStop && (stateQ != StIdle)) begin
        stopReqQ <= 1'b1;
      end
      if (runLaunch) begin
        acqCountQ <= '0;
      end else if ((stateQ == StWaitOnceClr) && !OnceEnd) begin
        acqCountQ <= acqCountInc;
      end
      if (runLaunch) begin
        trigDroppedQ <= '0;
      end else if (extEdge && !TrigMode && (stateQ != StWaitTrig) && (stateQ != StIdle) &&
                   (trigDroppedQ != 16'hFFFF)) begin
        trigDroppedQ <= trigDroppedQ + 16'd1;
      end
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once
  always_comb begin
    ModuleStart = 1'b0;
    AcqStart    = 1'b0;
    Running     = (stateQ != StIdle);
    unique case (stateQ)
      StArm, StWaitTrig, StWaitOnceEnd, StWaitOnceClr: ModuleStart = 1'b1;
      StTrigPulse: begin
        ModuleStart = 1'b1;
        AcqStart    = 1'b1;
      end
      default: ModuleStart = 1'b0;
    endcase
  end

  assign RunDone     = runDoneQ;
  assign AcqCount    = acqCountQ;
  assign TrigDropped = trigDroppedQ;

endmodule

// File: tb/tb_acq_trigger_scheduler.sv
module tb_acq_trigger_scheduler;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RunStart = 1'b0;
  logic        RunStop = 1'b0;
  logic        TrigMode = 1'b1;
  logic        ExtTrig = 1'b0;
  logic [15:0] TrigPeriod = 16'd100;
  logic [7:0]  TrigWidth = 8'd4;
  logic [15:0] AcqNumber = 16'd3;
  logic        OnceEnd = 1'b0;
  logic        AllDone = 1'b0;
  logic        ModuleStart, AcqStart, Running, RunDone;
  logic [15:0] AcqCount, TrigDropped;

  acq_trigger_scheduler #(.ARM_DELAY(64), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .reset_n(reset_n), .RunStart(RunStart), .RunStop(RunStop),
    .TrigMode(TrigMode), .ExtTrig(ExtTrig), .TrigPeriod(TrigPeriod), .TrigWidth(TrigWidth),
    .AcqNumber(AcqNumber), .OnceEnd(OnceEnd), .AllDone(AllDone), .ModuleStart(ModuleStart),
    .AcqStart(AcqStart), .Running(Running), .RunDone(RunDone), .AcqCount(AcqCount),
    .TrigDropped(TrigDropped)
  );

  always #5 Clk = ~Clk;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int pulseCnt = 0;
  int lastRise = 0;
  int widthBad = 0;
  int doneCnt = 0;
  int expWidth = 4;
  logic onceHold = 1'b0;

  always @(posedge Clk) cyc++;

  // Pulse monitor: counts AcqStart pulses, checks widths against expWidth, counts RunDone
  logic acqPrev = 1'b0;
  always @(negedge Clk) begin
    if (AcqStart && !acqPrev) begin
      pulseCnt++;
      lastRise = cyc;
    end
    if (!AcqStart && acqPrev && ((cyc - lastRise) != expWidth)) widthBad++;
    acqPrev = AcqStart;
    if (RunDone) doneCnt++;
  end

  // Slave readout model: OnceEnd high for 3 cycles, 50 cycles after each AcqStart rise
  logic oncePrev = 1'b0;
  initial begin
    forever begin
      @(negedge Clk);
      if (AcqStart && !oncePrev && !onceHold) begin
        oncePrev = 1'b1;
        repeat (50) @(negedge Clk);
        OnceEnd = 1'b1;
        repeat (3) @(negedge Clk);
        OnceEnd = 1'b0;
      end
      oncePrev = AcqStart;
    end
  end

  // Slave transmit model: AllDone pulses high for 10 cycles after ModuleStart falls mid-run
  logic msPrev = 1'b0;
  initial begin
    forever begin
      @(negedge Clk);
      if (msPrev && !ModuleStart && Running) begin
        repeat (5) @(negedge Clk);
        AllDone = 1'b1;
        repeat (10) @(negedge Clk);
        AllDone = 1'b0;
      end
      msPrev = ModuleStart;
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic waitPulses(input int target, input int budget, input string tag);
    int n = 0;
    bit ok;
    while (pulseCnt < target && n < budget) begin
      tick();
      n++;
    end
    ok = (pulseCnt >= target);
    checkValue(tag, 32'(ok), 32'd1);
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int n = 0;
    bit ok;
    while (doneCnt < target && n < budget) begin
      tick();
      n++;
    end
    ok = (doneCnt >= target);
    checkValue(tag, 32'(ok), 32'd1);
  endtask

  task automatic waitCount(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    bit ok;
    while (AcqCount != target && n < budget) begin
      tick();
      n++;
    end
    ok = (AcqCount == target);
    checkValue(tag, 32'(ok), 32'd1);
  endtask

  int startCyc = 0;
  task automatic startRun();
    RunStart = 1'b1;
    startCyc = cyc;
    tick();
    RunStart = 1'b0;
  endtask

  task automatic stopRun();
    RunStop = 1'b1;
    tick();
    RunStop = 1'b0;
  endtask

  task automatic pushExt();
    ExtTrig = 1'b1;
    tick();
    tick();
    ExtTrig = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int pBase, dBase, wBase, firstRise;

  initial begin
    // Reset state
    #1;
    checkValue("rst ModuleStart", 32'(ModuleStart), 32'd0);
    checkValue("rst AcqStart", 32'(AcqStart), 32'd0);
    checkValue("rst Running", 32'(Running), 32'd0);
    checkValue("rst RunDone", 32'(RunDone), 32'd0);
    checkValue("rst AcqCount", 32'(AcqCount), 32'd0);
    checkValue("rst TrigDropped", 32'(TrigDropped), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // 1: internal, period 100, width 4, 3 acquisitions
    pBase = pulseCnt; dBase = doneCnt; wBase = widthBad; expWidth = 4;
    startRun();
    checkValue("t1 ModuleStart up", 32'(ModuleStart), 32'd1);
    waitPulses(pBase + 1, 400, "t1 first pulse seen");
    firstRise = lastRise;
    // RunStart sampled at the edge after startCyc; AcqStart rises 165 edges later
    checkValue("t1 first rise delay", 32'(firstRise - startCyc), 32'd166);
    waitDone(dBase + 1, 1500, "t1 RunDone seen");
    checkValue("t1 pulses", 32'(pulseCnt - pBase), 32'd3);
    checkValue("t1 AcqCount", 32'(AcqCount), 32'd3);
    checkValue("t1 ModuleStart down", 32'(ModuleStart), 32'd0);
    repeat (20) tick();
    checkValue("t1 RunDone once", 32'(doneCnt - dBase), 32'd1);
    checkValue("t1 idle", 32'(Running), 32'd0);
    checkValue("t1 widths", 32'(widthBad - wBase), 32'd0);

    // 2: external, unlimited, 5 triggers + 2 dropped edges
    TrigMode = 1'b0; AcqNumber = 16'd0;
    pBase = pulseCnt; dBase = doneCnt; wBase = widthBad;
    startRun();
    repeat (70) tick();
    for (int i = 0; i < 5; i++) begin
      pushExt();
      waitPulses(pBase + i + 1, 50, "t2 trigger pulse");
      if (i < 2) begin
        repeat (10) tick();
        pushExt();
      end
      waitCount(16'(i + 1), 200, "t2 count step");
      repeat (3) tick();
    end
    checkValue("t2 pulses", 32'(pulseCnt - pBase), 32'd5);
    checkValue("t2 AcqCount", 32'(AcqCount), 32'd5);
    checkValue("t2 TrigDropped", 32'(TrigDropped), 32'd2);
    checkValue("t2 still running", 32'(Running), 32'd1);
    stopRun();
    waitDone(dBase + 1, 200, "t2 RunDone seen");
    repeat (20) tick();
    checkValue("t2 idle", 32'(Running), 32'd0);
    checkValue("t2 widths", 32'(widthBad - wBase), 32'd0);

    // 3: stop during WAIT_ONCE_END of acquisition 2
    TrigMode = 1'b1; TrigPeriod = 16'd20; AcqNumber = 16'd0;
    pBase = pulseCnt; dBase = doneCnt;
    startRun();
    waitPulses(pBase + 2, 600, "t3 second pulse");
    repeat (10) tick();
    stopRun();
    waitDone(dBase + 1, 300, "t3 RunDone seen");
    checkValue("t3 pulses", 32'(pulseCnt - pBase), 32'd2);
    checkValue("t3 AcqCount", 32'(AcqCount), 32'd2);
    checkValue("t3 ModuleStart down", 32'(ModuleStart), 32'd0);
    repeat (20) tick();
    checkValue("t3 no extra pulse", 32'(pulseCnt - pBase), 32'd2);

    // 4: period 0 and width 0 behave as 1
    TrigPeriod = 16'd0; TrigWidth = 8'd0; AcqNumber = 16'd2; expWidth = 1;
    pBase = pulseCnt; dBase = doneCnt; wBase = widthBad;
    startRun();
    waitPulses(pBase + 1, 200, "t4 first pulse");
    checkValue("t4 first rise delay", 32'(lastRise - startCyc), 32'd67);
    waitDone(dBase + 1, 500, "t4 RunDone seen");
    checkValue("t4 pulses", 32'(pulseCnt - pBase), 32'd2);
    checkValue("t4 widths", 32'(widthBad - wBase), 32'd0);
    checkValue("t4 AcqCount", 32'(AcqCount), 32'd2);
    repeat (20) tick();

    // 5: dropped-edge counting and saturation (slave held in readout)
    TrigMode = 1'b0; AcqNumber = 16'd0; TrigWidth = 8'd4; expWidth = 4; onceHold = 1'b1;
    pBase = pulseCnt;
    startRun();
    repeat (70) tick();
    pushExt();
    waitPulses(pBase + 1, 50, "t5 trigger pulse");
    repeat (10) tick();
    for (int i = 0; i < 1000; i++) begin
      ExtTrig = 1'b1;
      tick();
      ExtTrig = 1'b0;
      tick();
    end
    repeat (5) tick();
    checkValue("t5 dropped 1000", 32'(TrigDropped), 32'd1000);
    // Jump close to the ceiling rather than spend 130k cycles getting there
    force dut.trigDroppedQ = 16'hFFF0;
    tick();
    release dut.trigDroppedQ;
    tick();
    for (int i = 0; i < 100; i++) begin
      ExtTrig = 1'b1;
      tick();
      ExtTrig = 1'b0;
      tick();
    end
    repeat (5) tick();
    checkValue("t5 saturated", 32'(TrigDropped), 32'hFFFF);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    onceHold = 1'b0;
    repeat (3) tick();

    // 6: reset during TRIG_PULSE
    TrigMode = 1'b1; TrigPeriod = 16'd10; TrigWidth = 8'd4; AcqNumber = 16'd0;
    pBase = pulseCnt;
    startRun();
    waitPulses(pBase + 1, 200, "t6 pulse");
    checkValue("t6 AcqStart high", 32'(AcqStart), 32'd1);
    reset_n = 1'b0;
    #1;
    checkValue("t6 AcqStart async", 32'(AcqStart), 32'd0);
    checkValue("t6 ModuleStart async", 32'(ModuleStart), 32'd0);
    tick();
    reset_n = 1'b1;
    dBase = doneCnt;
    repeat (20) tick();
    checkValue("t6 idle", 32'(Running), 32'd0);
    checkValue("t6 AcqCount", 32'(AcqCount), 32'd0);
    checkValue("t6 TrigDropped", 32'(TrigDropped), 32'd0);
    checkValue("t6 no RunDone", 32'(doneCnt - dBase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
